// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send, then shifts
// one command byte, odd parity and stop on device clock edges and checks the device ACK.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       reset_L,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RELEASE,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic [INH_W-1:0] inh_q, inh_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [3:0]       n_q, n_d;
    logic             data_oe_q, data_oe_d;
    logic [7:0]       byte_q;
    logic             clk_s1_q, clk_s2_q, clk_s3_q;
    logic             data_s1_q, data_s2_q;

    logic accept_w;
    logic clk_oe_w;
    logic fall_w;
    logic inh_last_w;
    logic done_w;
    logic err_w;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    // Synchronizers idle high so that leaving reset never looks like a falling edge.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            clk_s3_q  <= 1'b1;
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
        end else begin
            clk_s1_q  <= ps2_clk_in;
            clk_s2_q  <= clk_s1_q;
            clk_s3_q  <= clk_s2_q;
            data_s1_q <= ps2_data_in;
            data_s2_q <= data_s1_q;
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= S_IDLE;
            inh_q     <= '0;
            to_q      <= '0;
            n_q       <= '0;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_q     <= inh_d;
            to_q      <= to_d;
            n_q       <= n_d;
            data_oe_q <= data_oe_d;
        end
    end

    always_ff @(posedge clock) begin
        if (accept_w) begin
            byte_q <= tx_data;
        end
    end

    assign accept_w   = tx_valid && (state_q == S_IDLE);
    assign clk_oe_w   = (state_q == S_INHIBIT);
    assign fall_w     = clk_s3_q && !clk_s2_q && !clk_oe_w;
    assign inh_last_w = (state_q == S_INHIBIT) && (inh_q == INH_LAST);

    always_comb begin
        state_d   = state_q;
        inh_d     = inh_q;
        to_d      = to_q;
        n_d       = n_q;
        data_oe_d = data_oe_q;
        done_w    = 1'b0;
        err_w     = 1'b0;
        case (state_q)
            S_IDLE: begin
                inh_d     = '0;
                data_oe_d = 1'b0;
                if (accept_w) begin
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                inh_d = inh_q + INH_W'(1);
                if (inh_q == INH_LAST) begin
                    inh_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = S_RELEASE;
                end
            end
            S_RELEASE: begin
                n_d     = '0;
                to_d    = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (fall_w) begin
                    n_d  = n_q + 4'd1;
                    to_d = '0;
                    // n_q is the edge count before this edge, so it indexes the next data bit.
                    if (n_q < 4'd8) begin
                        data_oe_d = ~byte_q[n_q[2:0]];
                    end else if (n_q == 4'd8) begin
                        data_oe_d = ~odd_parity(byte_q);
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = S_ACK;
                    end
                end else if (to_q == TO_LAST) begin
                    err_w     = 1'b1;
                    data_oe_d = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_ACK: begin
                if (fall_w) begin
                    to_d = '0;
                    if (data_s2_q) begin
                        err_w   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT_IDLE;
                    end
                end else if (to_q == TO_LAST) begin
                    err_w   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (clk_s2_q && data_s2_q) begin
                    done_w  = 1'b1;
                    state_d = S_IDLE;
                end else if (to_q == TO_LAST) begin
                    err_w   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            default: begin
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // The start bit appears in the last inhibit cycle; an error exit releases data at once.
    assign ps2_clk_oe  = clk_oe_w;
    assign ps2_data_oe = (data_oe_q || inh_last_w) && !err_w;
    assign tx_ready    = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign tx_done     = done_w;
    assign tx_error    = err_w;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- Complements the scan-code receive path: the receive path carries scan codes from the keyboard, and this block sends commands back to it.
- Drives the PS/2 clock and data lines through open-collector enables. Runs the full request-to-send, bit shifting, parity, stop and ACK sequence.
- Sits between command-issuing control logic and the PS/2 pad wrapper.

Parameters:
INHIBIT_CYCLES, 5000, cycles ps2_clk is held low before request-to-send (100 us at 50 MHz)
TIMEOUT_CYCLES, 1000000, maximum cycles allowed with no device falling edge, measured from clock release and between edges (20 ms at 50 MHz)

Ports:
clock  input  1  system clock, single domain
reset_L  input  1  asynchronous, active-low reset
tx_data  input  8  command byte
tx_valid  input  1  request to send tx_data
tx_ready  output  1  block idle and able to accept
ps2_clk_in  input  1  raw PS/2 clock pad value, asynchronous
ps2_data_in  input  1  raw PS/2 data pad value, asynchronous
ps2_clk_oe  output  1  1 = pull ps2_clk low; 0 = release (pad wrapper drives 0 or z)
ps2_data_oe  output  1  1 = pull ps2_data low; 0 = release
busy  output  1  transfer in progress
tx_done  output  1  one-cycle pulse: device ACKed and bus idle
tx_error  output  1  one-cycle pulse: no ACK or timeout

Behaviour:
- Reset (async, reset_L=0): state IDLE; tx_ready=1; ps2_clk_oe=0; ps2_data_oe=0; busy=0; tx_done=0; tx_error=0; all counters cleared.
- Input conditioning: ps2_clk_in and ps2_data_in pass through a 2-FF synchronizer. A falling edge is synced previous=1 and synced current=0. Edges are ignored while ps2_clk_oe=1.
- Handshake: a transfer is accepted on a cycle with tx_valid && tx_ready.
  - tx_data is latched on acceptance.
  - tx_ready=0 and busy=1 from the next cycle until the cycle after tx_done or tx_error.
  - tx_valid is ignored while busy.
- States:
  - IDLE: wait for acceptance, then go to INHIBIT.
  - INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles. In the last of these cycles ps2_data_oe rises to 1 (start bit 0). Then go to RELEASE.
  - RELEASE: ps2_clk_oe=0 and ps2_data_oe stays 1. Clear the edge counter n and the timeout counter. Go to SHIFT.
  - SHIFT: on each falling edge, n increments and the timeout counter clears.
    - n=1..8: ps2_data_oe = ~tx_data[n-1], LSB first.
    - n=9: ps2_data_oe = ~parity, with odd parity, parity = ~^tx_data.
    - n=10: ps2_data_oe=0 (stop bit 1). Go to ACK.
  - ACK: on the next falling edge (edge 11), sample the synced data.
    - Data 0: go to WAIT_IDLE.
    - Data 1: pulse tx_error and go to IDLE.
  - WAIT_IDLE: wait until synced clock=1 and synced data=1, then pulse tx_done and go to IDLE.
- Line updates: ps2_data_oe changes in the cycle after the falling edge is detected. That is 3 clocks after the pad edge, well inside the device's low phase.
- Timeout: active in SHIFT, ACK and WAIT_IDLE. If TIMEOUT_CYCLES cycles pass without a falling edge (or, in WAIT_IDLE, without reaching idle):
  - release both lines;
  - pulse tx_error;
  - go to IDLE.
- Exclusivity: tx_done and tx_error are never asserted together and are never asserted in the same cycle as acceptance.
- Line release on exit: both oe outputs are 0 in IDLE and in every cycle of an error exit.
- Counter widths: $clog2 of each parameter, plus 1; no wrap-around is possible before the terminal compare.
- Reset mid-transfer: outputs go immediately to their reset values (lines released). The next acceptance starts a fresh INHIBIT.

Test Plan:
- Send 0xED; device model clocks 11 edges and pulls data low at edge 11 -> INHIBIT lasts exactly 5000 cycles. Driven bits after start are 1,0,1,1,0,1,1,1, then parity 1, then stop 1. One tx_done pulse; tx_error stays 0; tx_ready returns to 1.
- Send 0x00 -> ps2_data_oe=1 for edges 1..8, 0 for parity (parity 1) and stop. tx_done pulses.
- Send 0xFF, device leaves data high at edge 11 -> tx_error pulses once; tx_done=0; both oe=0; block accepts the next byte.
- Device never clocks after release -> tx_error exactly TIMEOUT_CYCLES cycles after RELEASE (use a small parameter, e.g. 200). Lines released.
- tx_valid held high throughout a transfer with changing tx_data -> only the first byte is sent; a second transfer starts only after tx_done.
- reset_L driven low during data bit 4 -> ps2_clk_oe=ps2_data_oe=0 and tx_ready=1 asynchronously. A subsequent 0xF4 transfer completes with tx_done.
